// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module  : uart_pkg                                                    |
// | Brief   : Shared constants, state encoding and divider helper for the |
// |           16x-oversampling UART receiver.                             |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package uart_pkg;

  localparam int CLK_FREQ_HZ = 10_000_000;
  localparam int BAUD        = 9600;
  localparam int OVERSAMPLE  = 16;
  localparam int DATA_BITS   = 8;

  // Rounded integer division so the bit period error stays below half a clock per tick
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  localparam int DIV    = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int MID    = OVERSAMPLE / 2;
  localparam int TCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module  : uart_baud_tick                                              |
// | Brief   : Free-running oversample tick divider, restartable by clr_i. |
// |           tick_o is high for one cycle when the count hits DIVISOR-1. |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module uart_baud_tick #(
  parameter int DIVISOR = 65
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(DIVISOR);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap at DIVISOR-1; a clear restarts the phase so ticks align to the start edge
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == CW'(DIVISOR - 1))) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == CW'(DIVISOR - 1));

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module  : uart_rx_core                                                |
// | Brief   : 16x-oversampling UART receiver with one-deep holding        |
// |           register and sticky framing/overrun flags.                  |
// |           Define UART_PARITY_EN for 8E1 frames with parity checking;  |
// |           otherwise frames are 8N1 and parity_err_o is tied low.      |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module uart_rx_core
  import uart_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic                 rd_ack_i,
  input  logic                 clr_err_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_rdy_o,
  output logic                 rx_pulse_o,
  output logic                 busy_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 parity_err_o
);

  logic                 sync1_q, sync2_q, prev_q;
  logic                 w_fall, w_tick, w_clr_tick;
  logic                 w_ferr_set;
  rx_state_t            state_q, state_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 commit_q, commit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 pulse_q, pulse_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_PARITY_EN
  logic                 w_perr_set;
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  // Synchroniser and edge register idle high so reset never fakes a start edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign w_fall     = prev_q & ~sync2_q;
  assign w_clr_tick = (state_q == IDLE) & w_fall;

  uart_baud_tick #(
    .DIVISOR (DIV)
  ) u_baud_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (w_clr_tick),
    .tick_o (w_tick)
  );

  // Frame sequencing: centre-sample start, data, optional parity, and stop bits
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    commit_d   = 1'b0;
    w_ferr_set = 1'b0;
`ifdef UART_PARITY_EN
    w_perr_set = 1'b0;
    par_bad_d  = par_bad_q;
`endif
    unique case (state_q)
      IDLE: begin
        tcnt_d = '0;
        bcnt_d = '0;
`ifdef UART_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (w_fall) state_d = START;
      end
      START: begin
        if (w_tick) begin
          if (tcnt_q == TCNT_W'(MID - 1)) begin
            tcnt_d  = '0;
            state_d = sync2_q ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (tcnt_q == TCNT_W'(OVERSAMPLE - 1)) begin
            tcnt_d  = '0;
            shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
            if (bcnt_q == BCNT_W'(DATA_BITS - 1)) begin
              bcnt_d = '0;
`ifdef UART_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + BCNT_W'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          if (tcnt_q == TCNT_W'(OVERSAMPLE - 1)) begin
            tcnt_d  = '0;
            state_d = STOP;
            if (sync2_q != (^shift_q)) begin
              w_perr_set = 1'b1;
              par_bad_d  = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (w_tick) begin
          if (tcnt_q == TCNT_W'(OVERSAMPLE - 1)) begin
            tcnt_d  = '0;
            state_d = IDLE;
            if (sync2_q) begin
`ifdef UART_PARITY_EN
              commit_d = ~par_bad_q;
`else
              commit_d = 1'b1;
`endif
            end else begin
              w_ferr_set = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register and sticky flags; a flag being set beats a same-cycle clear
  always_comb begin
    data_d  = data_q;
    rdy_d   = rdy_q;
    pulse_d = 1'b0;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (clr_err_i) begin
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (w_ferr_set) ferr_d = 1'b1;
    if (commit_q) begin
      if (rdy_q && !rd_ack_i) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        rdy_d   = 1'b1;
        pulse_d = 1'b1;
      end
    end else if (rd_ack_i) begin
      rdy_d = 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  // Parity error flag follows the same set-over-clear rule
  always_comb begin
    perr_d = perr_q;
    if (clr_err_i)  perr_d = 1'b0;
    if (w_perr_set) perr_d = 1'b1;
  end

  // Parity flag registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
    end
  end

  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  // State, counters, shift register and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      commit_q <= 1'b0;
      data_q   <= '0;
      rdy_q    <= 1'b0;
      pulse_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      commit_q <= commit_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      pulse_q  <= pulse_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign data_rdy_o  = rdy_q;
  assign rx_pulse_o  = pulse_q;
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule
`default_nettype wire
